ride_session_ctrl: RTL and testbench

- Sequences the ride datapath (revolution/distance/speed counters and session timer).
- Generates the ms and 1 s tick enables from clk.
- Debounces the raw wheel sensor and gates revolutions by session state.
- Measures the revolution period in ms and computes speed with a multi-cycle divider, so the datapath needs no combinational divide or second clock domain.

---
 rtl/ride_session_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ride_session_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ride_session_ctrl.sv
`timescale 1ns/1ps
// ride_session_ctrl
// Session sequencer for the ride datapath. Generates the 1 ms / 1 s tick
// enables, debounces the wheel sensor, qualifies revolutions by session
// state, measures the revolution period in ms and derives speed with a
// bit-serial restoring divider.
//
// Optional build macro: AUTO_PAUSE_EN
//   defined   : a stall in RUNNING pauses the session; a debounced wheel
//               edge in PAUSED resumes it (no clear, no rev_pulse).
//   undefined : a stall only forces speed to 0.
//
// Ports
//   clk          in   system clock
//   reset        in   async reset, active-low
//   start        in   start/resume request pulse
//   stop         in   pause/end request pulse (wins over start)
//   rev_in       in   raw wheel sensor, asynchronous
//   rev_pulse    out  qualified revolution strobe (RUNNING only)
//   ms_tick      out  1 ms strobe, free-running
//   sec_tick     out  1 s strobe, counts RUNNING time only
//   clear        out  one-cycle datapath clear
//   run          out  high in RUNNING
//   state        out  00 IDLE, 01 RUNNING, 10 PAUSED, 11 DONE
//   elapsed_s    out  seconds spent in RUNNING (saturating)
//   period_ms    out  last measured revolution period
//   speed_mps    out  speed in m/s, 0..99
//   speed_valid  out  strobe when speed_mps updates
//   times_up     out  high in DONE
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no session, waiting for start
// RUNNING  | session active, time and revolutions counted
// PAUSED   | session held, counters frozen
// DONE     | session length reached, results held
module ride_session_ctrl #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int WHEEL_M     = 2,
  parameter int DEBOUNCE_MS = 5,
  parameter int STALL_MS    = 3000,
  parameter int SESSION_S   = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        rev_in,
  output logic        rev_pulse,
  output logic        ms_tick,
  output logic        sec_tick,
  output logic        clear,
  output logic        run,
  output logic [1:0]  state,
  output logic [11:0] elapsed_s,
  output logic [15:0] period_ms,
  output logic [6:0]  speed_mps,
  output logic        speed_valid,
  output logic        times_up
);

  localparam int MS_DIV = CLK_HZ / 1000;
  localparam int MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [MS_W-1:0] MS_LAST      = MS_W'(MS_DIV - 1);
  localparam logic [15:0]     DIVIDEND     = 16'(WHEEL_M * 1000);
  localparam logic [15:0]     STALL_LAST   = 16'(STALL_MS - 1);
  localparam logic [15:0]     STALL_MAX    = 16'(STALL_MS);
  localparam logic [11:0]     SESSION_LAST = 12'(SESSION_S - 1);
  localparam logic [7:0]      DEB_LAST     = 8'(DEBOUNCE_MS - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  logic [MS_W-1:0] ms_cnt;
  logic [9:0]      sec_cnt;
  logic            sync1, sync2, deb, deb_d;
  logic [7:0]      deb_cnt;
  logic [15:0]     per_cnt;
  logic            have_ref;
  logic [1:0]      state_nxt;
  logic            do_clear, deb_rise, stall, pause_resume, auto_resume;
  logic            div_busy, div_start, q_bit;
  logic [3:0]      div_it;
  logic [15:0]     div_rem, div_quo, div_dsr, quo_nxt;
  logic [16:0]     rem_sh, rem_sub;

  assign ms_tick   = (ms_cnt == MS_LAST);
  assign run       = (state == ST_RUN);
  assign times_up  = (state == ST_DONE);
  assign sec_tick  = run && ms_tick && (sec_cnt == 10'd999);
  assign deb_rise  = deb && !deb_d;
  assign rev_pulse = deb_rise && run;
  // A revolution in the same tick takes precedence: it restarts the counter.
  assign stall     = run && ms_tick && (per_cnt == STALL_LAST) && !rev_pulse;
  assign pause_resume = (state == ST_PAUSE) && start && !stop;
  assign div_start = rev_pulse && have_ref;

`ifdef AUTO_PAUSE_EN
  assign auto_resume = (state == ST_PAUSE) && deb_rise && !start && !stop;
`else
  assign auto_resume = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    do_clear  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nxt = ST_RUN;
          do_clear  = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) state_nxt = ST_PAUSE;
        else if (sec_tick && elapsed_s == SESSION_LAST) state_nxt = ST_DONE;
`ifdef AUTO_PAUSE_EN
        else if (stall) state_nxt = ST_PAUSE;
`endif
      end
      ST_PAUSE: begin
        if (stop) begin
          state_nxt = ST_IDLE;
          do_clear  = 1'b1;
        end else if (start || auto_resume) begin
          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_nxt = ST_IDLE;
          do_clear  = 1'b1;
        end else if (start) begin
          state_nxt = ST_RUN;
          do_clear  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      clear <= 1'b0;
    end else begin
      state <= state_nxt;
      clear <= do_clear;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_cnt    <= '0;
      sec_cnt   <= '0;
      elapsed_s <= '0;
    end else begin
      ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
      if (do_clear) begin
        sec_cnt   <= '0;
        elapsed_s <= '0;
      end else begin
        if (run && ms_tick) sec_cnt <= sec_tick ? 10'd0 : sec_cnt + 10'd1;
        if (sec_tick && elapsed_s != 12'hfff) elapsed_s <= elapsed_s + 12'd1;
      end
    end
  end

  // The debounced level only moves after DEBOUNCE_MS consecutive ms ticks
  // that all saw the synchronized input disagree with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= rev_in;
      sync2 <= sync1;
      deb_d <= deb;
      if (ms_tick) begin
        if (sync2 != deb) begin
          if (deb_cnt == DEB_LAST) begin
            deb     <= sync2;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + 8'd1;
          end
        end else begin
          deb_cnt <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt   <= '0;
      have_ref  <= 1'b0;
      period_ms <= '0;
    end else if (do_clear) begin
      per_cnt   <= '0;
      have_ref  <= 1'b0;
      period_ms <= '0;
    end else if (rev_pulse) begin
      if (have_ref) period_ms <= per_cnt;
      per_cnt  <= '0;
      have_ref <= 1'b1;
    end else begin
      if (run && ms_tick && per_cnt != STALL_MAX) per_cnt <= per_cnt + 16'd1;
      // Time spent paused must never be measured as a revolution period.
      if (stall || pause_resume) have_ref <= 1'b0;
      if (auto_resume) begin
        have_ref <= 1'b1;
        per_cnt  <= '0;
      end
    end
  end

  // One restoring-division step per cycle: shift in the next dividend bit,
  // trial-subtract the divisor, keep the difference when it does not borrow.
  assign rem_sh  = {div_rem, div_quo[15]};
  assign rem_sub = rem_sh - {1'b0, div_dsr};
  assign q_bit   = !rem_sub[16];
  assign quo_nxt = {div_quo[14:0], q_bit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_busy    <= 1'b0;
      div_it      <= '0;
      div_rem     <= '0;
      div_quo     <= '0;
      div_dsr     <= '0;
      speed_mps   <= '0;
      speed_valid <= 1'b0;
    end else begin
      speed_valid <= 1'b0;
      if (do_clear) begin
        div_busy  <= 1'b0;
        speed_mps <= '0;
      end else if (div_start) begin
        div_busy <= 1'b1;
        div_it   <= '0;
        div_rem  <= '0;
        div_quo  <= DIVIDEND;
        div_dsr  <= per_cnt;
      end else if (stall) begin
        div_busy    <= 1'b0;
        speed_mps   <= '0;
        speed_valid <= 1'b1;
      end else if (div_busy) begin
        div_rem <= q_bit ? rem_sub[15:0] : rem_sh[15:0];
        div_quo <= quo_nxt;
        div_it  <= div_it + 4'd1;
        if (div_it == 4'd15) begin
          div_busy    <= 1'b0;
          speed_valid <= 1'b1;
          speed_mps   <= (div_dsr == 16'd0 || quo_nxt > 16'd99) ? 7'd99 : quo_nxt[6:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_ride_session_ctrl.sv
`timescale 1ns/1ps
module tb_ride_session_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        rev_man = 1'b0;
  logic        rev_bg = 1'b0;
  logic        bg_en = 1'b0;
  logic        rev_in;
  logic        rev_pulse, ms_tick, sec_tick, clear, run, speed_valid, times_up;
  logic [1:0]  state;
  logic [11:0] elapsed_s;
  logic [15:0] period_ms;
  logic [6:0]  speed_mps;

  assign rev_in = rev_man | rev_bg;

  ride_session_ctrl #(
    .CLK_HZ(10_000), .WHEEL_M(2), .DEBOUNCE_MS(2), .STALL_MS(50), .SESSION_S(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .rev_in(rev_in),
    .rev_pulse(rev_pulse), .ms_tick(ms_tick), .sec_tick(sec_tick), .clear(clear),
    .run(run), .state(state), .elapsed_s(elapsed_s), .period_ms(period_ms),
    .speed_mps(speed_mps), .speed_valid(speed_valid), .times_up(times_up)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int rp_cnt = 0, sv_cnt = 0, clr_cnt = 0, sec_n = 0;
  int rp_cyc = 0, sv_cyc = 0;
  int sv_period = 0, sv_speed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rev_pulse) begin rp_cnt++; rp_cyc = cyc; end
    if (speed_valid) begin
      sv_cnt++; sv_cyc = cyc; sv_period = int'(period_ms); sv_speed = int'(speed_mps);
    end
    if (clear) clr_cnt++;
    if (sec_tick) sec_n++;
  end

  // Background wheel: one revolution every 20 ms while enabled.
  initial begin
    forever begin
      if (bg_en) begin
        rev_bg = 1'b1;
        repeat (40) @(posedge clk);
        #1 rev_bg = 1'b0;
        repeat (160) @(posedge clk);
        #1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p);
    start = s;
    stop  = p;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Rising edge lands gap_ms after the previous call's rising edge.
  task automatic rev_at(input int gap_ms);
    tick(gap_ms * 10 - 60);
    rev_man = 1'b1;
    tick(40);
    rev_man = 1'b0;
    tick(20);
  endtask

  function automatic longint all_outs();
    return {rev_pulse, ms_tick, sec_tick, clear, run, state, elapsed_s,
            period_ms, speed_mps, speed_valid, times_up};
  endfunction

  typedef struct {
    int gap_ms;
    int exp_sv;
    int exp_period;
    int exp_speed;
  } vec_t;

  vec_t vecs[8];
  int rp0, sv0, clr0, sc0, n;

  initial begin
    vecs[0] = '{10, 0, 0,  0};
    vecs[1] = '{20, 1, 20, 99};
    vecs[2] = '{40, 1, 40, 50};
    vecs[3] = '{21, 1, 21, 95};
    vecs[4] = '{49, 1, 49, 40};
    vecs[5] = '{25, 1, 25, 80};
    vecs[6] = '{10, 1, 10, 99};
    vecs[7] = '{45, 1, 45, 44};

    tick(5);
    chk("reset_outputs", all_outs(), 0);
    reset = 1'b1;
    tick(2);
    chk("idle_state", state, 0);

    rp0 = rp_cnt;
    rev_man = 1'b1; tick(40); rev_man = 1'b0; tick(40);
    chk("idle_rev_no_pulse", rp_cnt - rp0, 0);
    chk("idle_no_sec_tick", sec_n, 0);

    clr0 = clr_cnt;
    pulse(1'b1, 1'b0);
    chk("start_state", state, 1);
    chk("start_run", run, 1);
    tick(1);
    chk("start_clear", clr_cnt - clr0, 1);

    for (int i = 0; i < 8; i++) begin
      rp0 = rp_cnt;
      sv0 = sv_cnt;
      rev_at(vecs[i].gap_ms);
      chk($sformatf("vec%0d_rev_pulse", i), rp_cnt - rp0, 1);
      chk($sformatf("vec%0d_speed_valid_count", i), sv_cnt - sv0, vecs[i].exp_sv);
      if (vecs[i].exp_sv != 0) begin
        chk($sformatf("vec%0d_period", i), sv_period, vecs[i].exp_period);
        chk($sformatf("vec%0d_speed", i), sv_speed, vecs[i].exp_speed);
        chk($sformatf("vec%0d_latency", i), sv_cyc - rp_cyc, 17);
        chk($sformatf("vec%0d_period_out", i), period_ms, vecs[i].exp_period);
      end
    end

    // Stall: 50 ms without a revolution.
    sv0 = sv_cnt;
    tick(600);
    chk("stall_speed_valid", sv_cnt - sv0, 1);
    chk("stall_speed_zero", sv_speed, 0);
    chk("stall_speed_out", speed_mps, 0);
`ifdef AUTO_PAUSE_EN
    chk("stall_state_paused", state, 2);
`else
    chk("stall_state_running", state, 1);
`endif
    rp0 = rp_cnt;
    sv0 = sv_cnt;
    rev_at(70);
`ifdef AUTO_PAUSE_EN
    chk("resume_no_rev_pulse", rp_cnt - rp0, 0);
`else
    chk("rearm_rev_pulse", rp_cnt - rp0, 1);
`endif
    chk("rearm_no_speed_update", sv_cnt - sv0, 0);
    chk("after_stall_state", state, 1);
    rp0 = rp_cnt;
    sv0 = sv_cnt;
    rev_at(30);
    chk("post_stall_rev_pulse", rp_cnt - rp0, 1);
    chk("post_stall_speed_valid", sv_cnt - sv0, 1);
    chk("post_stall_period", sv_period, 30);
    chk("post_stall_speed", sv_speed, 66);

    // 0.8 ms glitch is shorter than the debounce window.
    tick(50);
    rp0 = rp_cnt;
    rev_man = 1'b1; tick(8); rev_man = 1'b0; tick(100);
    chk("glitch_no_rev_pulse", rp_cnt - rp0, 0);

    // Reset in the middle of a division discards the result.
    sv0 = sv_cnt;
    rp0 = rp_cnt;
    tick(100);
    rev_man = 1'b1;
    n = 0;
    while (rp_cnt == rp0 && n < 40) begin tick(1); n++; end
    chk("pre_reset_rev_pulse", rp_cnt - rp0, 1);
    tick(5);
    reset = 1'b0;
    tick(3);
    chk("midrun_reset_outputs", all_outs(), 0);
    rev_man = 1'b0;
    reset = 1'b1;
    n = 0;
    while (!ms_tick && n < 30) begin tick(1); n++; end
    chk("ms_tick_first_found", (n < 30) ? 1 : 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      n = 1;
      while (!ms_tick && n < 30) begin tick(1); n++; end
      chk($sformatf("ms_tick_period%0d", k), n, 10);
    end
    tick(20);
    chk("reset_discards_division", sv_cnt - sv0, 0);
    chk("reset_speed_zero", speed_mps, 0);
    chk("reset_state_idle", state, 0);

    // Session: 1.5 s run, pause, resume until DONE.
    sc0 = sec_n;
    clr0 = clr_cnt;
    pulse(1'b1, 1'b0);
    bg_en = 1'b1;
    tick(14800);
    bg_en = 1'b0;
    tick(200);
    chk("session_elapsed_1", elapsed_s, 1);
    pulse(1'b0, 1'b1);
    chk("session_paused", state, 2);
`ifndef AUTO_PAUSE_EN
    rp0 = rp_cnt;
    rev_man = 1'b1; tick(40); rev_man = 1'b0; tick(40);
    chk("paused_rev_no_pulse", rp_cnt - rp0, 0);
`endif
    tick(3000);
    chk("paused_elapsed_held", elapsed_s, 1);
    chk("paused_no_sec_tick", sec_n - sc0, 1);
    pulse(1'b1, 1'b0);
    bg_en = 1'b1;
    chk("resume_state", state, 1);
    tick(1);
    chk("resume_no_clear", clr_cnt - clr0, 1);
    chk("resume_elapsed", elapsed_s, 1);
    tick(14000);
    chk("pre_done_state", state, 1);
    chk("pre_done_elapsed", elapsed_s, 2);
    tick(2000);
    chk("done_state", state, 3);
    chk("done_times_up", times_up, 1);
    chk("done_elapsed", elapsed_s, 3);
    chk("done_sec_ticks", sec_n - sc0, 3);

    // start and stop together: stop wins.
    bg_en = 1'b0;
    tick(200);
    clr0 = clr_cnt;
    pulse(1'b1, 1'b1);
    chk("done_both_to_idle", state, 0);
    tick(1);
    chk("done_stop_clear", clr_cnt - clr0, 1);
    chk("cleared_elapsed", elapsed_s, 0);
    chk("cleared_period", period_ms, 0);
    chk("cleared_speed", speed_mps, 0);
    pulse(1'b1, 1'b0);
    chk("restart_running", state, 1);
    tick(20);
    pulse(1'b1, 1'b1);
    chk("running_both_to_paused", state, 2);
    pulse(1'b1, 1'b1);
    chk("paused_both_to_idle", state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
